// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bundle: decoded ID-stage fields in, registered EX-stage
// copies, hazard-control outputs and event counters back out.
interface id_ex_stage_if #(parameter int XLEN = 32);
  logic [4:0]      IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_RegisterRd;
  logic            ID_UsesRs1, ID_UsesRs2;
  logic [XLEN-1:0] IF_ID_PC, ID_ReadData1, ID_ReadData2, ID_Imm;
  logic            ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_Branch, ID_ALUSrc;
  logic [1:0]      ID_ALUOp;
  logic [3:0]      ID_ALUCtrl;
  logic            EX_Flush;

  logic [4:0]      ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd;
  logic [XLEN-1:0] ID_EX_PC, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
  logic            ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
  logic            ID_EX_Branch, ID_EX_ALUSrc;
  logic [1:0]      ID_EX_ALUOp;
  logic [3:0]      ID_EX_ALUCtrl;
  logic            ID_EX_Valid;
  logic            PCWrite, IF_ID_Write;
  logic [15:0]     StallCount, FlushCount;

  modport master (
    output IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_RegisterRd, ID_UsesRs1, ID_UsesRs2,
           IF_ID_PC, ID_ReadData1, ID_ReadData2, ID_Imm, ID_RegWrite, ID_MemRead,
           ID_MemWrite, ID_MemtoReg, ID_Branch, ID_ALUSrc, ID_ALUOp, ID_ALUCtrl, EX_Flush,
    input  ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd, ID_EX_PC,
           ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_RegWrite, ID_EX_MemRead,
           ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_Branch, ID_EX_ALUSrc, ID_EX_ALUOp,
           ID_EX_ALUCtrl, ID_EX_Valid, PCWrite, IF_ID_Write, StallCount, FlushCount
  );

  modport slave (
    input  IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_RegisterRd, ID_UsesRs1, ID_UsesRs2,
           IF_ID_PC, ID_ReadData1, ID_ReadData2, ID_Imm, ID_RegWrite, ID_MemRead,
           ID_MemWrite, ID_MemtoReg, ID_Branch, ID_ALUSrc, ID_ALUOp, ID_ALUCtrl, EX_Flush,
    output ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd, ID_EX_PC,
           ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_RegWrite, ID_EX_MemRead,
           ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_Branch, ID_EX_ALUSrc, ID_EX_ALUOp,
           ID_EX_ALUCtrl, ID_EX_Valid, PCWrite, IF_ID_Write, StallCount, FlushCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush-driven bubble
// insertion and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);
  logic rdHit;
  logic loadUse;
  logic stall;

  // A bubble (Valid = 0) or a load into x0 can never create a hazard.
  always_comb begin
    rdHit   = (bus.ID_UsesRs1 && (bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRs1)) ||
              (bus.ID_UsesRs2 && (bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRs2));
    loadUse = bus.ID_EX_Valid && bus.ID_EX_MemRead && (bus.ID_EX_RegisterRd != 5'd0) && rdHit;
    stall   = loadUse && !bus.EX_Flush;
    bus.PCWrite     = !stall;
    bus.IF_ID_Write = !stall;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ID_EX_RegisterRs1 <= 5'd0;
      bus.ID_EX_RegisterRs2 <= 5'd0;
      bus.ID_EX_RegisterRd  <= 5'd0;
      bus.ID_EX_PC          <= {XLEN{1'b0}};
      bus.ID_EX_ReadData1   <= {XLEN{1'b0}};
      bus.ID_EX_ReadData2   <= {XLEN{1'b0}};
      bus.ID_EX_Imm         <= {XLEN{1'b0}};
      bus.ID_EX_RegWrite    <= 1'b0;
      bus.ID_EX_MemRead     <= 1'b0;
      bus.ID_EX_MemWrite    <= 1'b0;
      bus.ID_EX_MemtoReg    <= 1'b0;
      bus.ID_EX_Branch      <= 1'b0;
      bus.ID_EX_ALUSrc      <= 1'b0;
      bus.ID_EX_ALUOp       <= 2'd0;
      bus.ID_EX_ALUCtrl     <= 4'd0;
      bus.ID_EX_Valid       <= 1'b0;
      bus.StallCount        <= 16'd0;
      bus.FlushCount        <= 16'd0;
    end else begin
      if (stall && (bus.StallCount != 16'hFFFF)) bus.StallCount <= bus.StallCount + 16'd1;
      if (bus.EX_Flush && (bus.FlushCount != 16'hFFFF)) bus.FlushCount <= bus.FlushCount + 16'd1;

      if (bus.EX_Flush || stall) begin
        bus.ID_EX_RegisterRs1 <= 5'd0;
        bus.ID_EX_RegisterRs2 <= 5'd0;
        bus.ID_EX_RegisterRd  <= 5'd0;
        bus.ID_EX_PC          <= {XLEN{1'b0}};
        bus.ID_EX_ReadData1   <= {XLEN{1'b0}};
        bus.ID_EX_ReadData2   <= {XLEN{1'b0}};
        bus.ID_EX_Imm         <= {XLEN{1'b0}};
        bus.ID_EX_RegWrite    <= 1'b0;
        bus.ID_EX_MemRead     <= 1'b0;
        bus.ID_EX_MemWrite    <= 1'b0;
        bus.ID_EX_MemtoReg    <= 1'b0;
        bus.ID_EX_Branch      <= 1'b0;
        bus.ID_EX_ALUSrc      <= 1'b0;
        bus.ID_EX_ALUOp       <= 2'd0;
        bus.ID_EX_ALUCtrl     <= 4'd0;
        bus.ID_EX_Valid       <= 1'b0;
      end else begin
        bus.ID_EX_RegisterRs1 <= bus.IF_ID_RegisterRs1;
        bus.ID_EX_RegisterRs2 <= bus.IF_ID_RegisterRs2;
        bus.ID_EX_RegisterRd  <= bus.IF_ID_RegisterRd;
        bus.ID_EX_PC          <= bus.IF_ID_PC;
        bus.ID_EX_ReadData1   <= bus.ID_ReadData1;
        bus.ID_EX_ReadData2   <= bus.ID_ReadData2;
        bus.ID_EX_Imm         <= bus.ID_Imm;
        bus.ID_EX_RegWrite    <= bus.ID_RegWrite;
        bus.ID_EX_MemRead     <= bus.ID_MemRead;
        bus.ID_EX_MemWrite    <= bus.ID_MemWrite;
        bus.ID_EX_MemtoReg    <= bus.ID_MemtoReg;
        bus.ID_EX_Branch      <= bus.ID_Branch;
        bus.ID_EX_ALUSrc      <= bus.ID_ALUSrc;
        bus.ID_EX_ALUOp       <= bus.ID_ALUOp;
        bus.ID_EX_ALUCtrl     <= bus.ID_ALUCtrl;
        bus.ID_EX_Valid       <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/reset scenarios plus
// randomized traffic compared against a cycle-level reference model.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, rd1, rd2, imm;
    logic        regWrite, memRead, memWrite, memtoReg, branch, aluSrc;
    logic [1:0]  aluOp;
    logic [3:0]  aluCtrl;
  } idEx_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN)) bus ();
  id_ex_stage #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: what ID/EX should hold, plus the expected counters.
  idEx_t       expReg;
  logic        expValid;
  logic [15:0] expStallCnt, expFlushCnt;
  idEx_t       cur;
  logic        curU1, curU2, curFlush;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic idEx_t dutIdEx();
    idEx_t v;
    v.rs1 = bus.ID_EX_RegisterRs1;  v.rs2 = bus.ID_EX_RegisterRs2;  v.rd = bus.ID_EX_RegisterRd;
    v.pc = bus.ID_EX_PC;  v.rd1 = bus.ID_EX_ReadData1;  v.rd2 = bus.ID_EX_ReadData2;
    v.imm = bus.ID_EX_Imm;  v.regWrite = bus.ID_EX_RegWrite;  v.memRead = bus.ID_EX_MemRead;
    v.memWrite = bus.ID_EX_MemWrite;  v.memtoReg = bus.ID_EX_MemtoReg;  v.branch = bus.ID_EX_Branch;
    v.aluSrc = bus.ID_EX_ALUSrc;  v.aluOp = bus.ID_EX_ALUOp;  v.aluCtrl = bus.ID_EX_ALUCtrl;
    return v;
  endfunction

  task automatic drive(input idEx_t v, input logic u1, input logic u2, input logic fl);
    cur = v;  curU1 = u1;  curU2 = u2;  curFlush = fl;
    bus.IF_ID_RegisterRs1 = v.rs1;  bus.IF_ID_RegisterRs2 = v.rs2;  bus.IF_ID_RegisterRd = v.rd;
    bus.IF_ID_PC = v.pc;  bus.ID_ReadData1 = v.rd1;  bus.ID_ReadData2 = v.rd2;  bus.ID_Imm = v.imm;
    bus.ID_RegWrite = v.regWrite;  bus.ID_MemRead = v.memRead;  bus.ID_MemWrite = v.memWrite;
    bus.ID_MemtoReg = v.memtoReg;  bus.ID_Branch = v.branch;  bus.ID_ALUSrc = v.aluSrc;
    bus.ID_ALUOp = v.aluOp;  bus.ID_ALUCtrl = v.aluCtrl;
    bus.ID_UsesRs1 = u1;  bus.ID_UsesRs2 = u2;  bus.EX_Flush = fl;
  endtask

  function automatic idEx_t instr(input int rs1, input int rs2, input int rd, input logic memRead,
                                  input logic regWrite, input logic [31:0] pc);
    idEx_t v = '0;
    v.rs1 = 5'(rs1);  v.rs2 = 5'(rs2);  v.rd = 5'(rd);
    v.memRead = memRead;  v.regWrite = regWrite;  v.pc = pc;
    return v;
  endfunction

  function automatic idEx_t randIn();
    idEx_t v;
    v.rs1 = 5'($urandom_range(0, 3));  v.rs2 = 5'($urandom_range(0, 3));
    v.rd  = 5'($urandom_range(0, 3));
    v.pc = $urandom;  v.rd1 = $urandom;  v.rd2 = $urandom;  v.imm = $urandom;
    v.regWrite = 1'($urandom);  v.memRead = 1'($urandom);  v.memWrite = 1'($urandom);
    v.memtoReg = 1'($urandom);  v.branch = 1'($urandom);  v.aluSrc = 1'($urandom);
    v.aluOp = 2'($urandom);  v.aluCtrl = 4'($urandom);
    return v;
  endfunction

  task automatic modelReset();
    expReg = '0;  expValid = 1'b0;  expStallCnt = 16'd0;  expFlushCnt = 16'd0;
  endtask

  task automatic checkOutputs(input string tag);
    check({tag, "_idex"}, dutIdEx(), expReg);
    check({tag, "_valid"}, bus.ID_EX_Valid, expValid);
    check({tag, "_stallcnt"}, bus.StallCount, expStallCnt);
    check({tag, "_flushcnt"}, bus.FlushCount, expFlushCnt);
  endtask

  // Called just after a falling edge with inputs already driven; returns just after the next one.
  task automatic step(input string tag);
    logic lu, st;
    #1;
    lu = expValid && expReg.memRead && (expReg.rd != 5'd0) &&
         ((curU1 && expReg.rd == cur.rs1) || (curU2 && expReg.rd == cur.rs2));
    st = lu && !curFlush;
    check({tag, "_pcwrite"}, bus.PCWrite, !st);
    check({tag, "_ifidwrite"}, bus.IF_ID_Write, !st);
    @(posedge clk);
    #1;
    if (st && expStallCnt != 16'hFFFF) expStallCnt = expStallCnt + 16'd1;
    if (curFlush && expFlushCnt != 16'hFFFF) expFlushCnt = expFlushCnt + 16'd1;
    if (st || curFlush) begin
      expReg = '0;  expValid = 1'b0;
    end else begin
      expReg = cur;  expValid = 1'b1;
    end
    checkOutputs(tag);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    modelReset();
    drive(instr(1, 2, 3, 1'b1, 1'b1, 32'h40), 1'b1, 1'b1, 1'b0);
    #3;
    checkOutputs("reset");
    check("reset_pcwrite", bus.PCWrite, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Pass-through with no hazard.
    drive(instr(5, 6, 7, 1'b0, 1'b1, 32'h100), 1'b1, 1'b1, 1'b0);
    step("pass");
    check("pass_pc", bus.ID_EX_PC, 32'h100);
    check("pass_rd", bus.ID_EX_RegisterRd, 5'd7);

    // Load-use: one stall cycle, then the held add is captured.
    drive(instr(1, 2, 5, 1'b1, 1'b1, 32'h104), 1'b1, 1'b0, 1'b0);
    step("lw");
    drive(instr(5, 3, 8, 1'b0, 1'b1, 32'h108), 1'b1, 1'b1, 1'b0);
    #1 check("lu_pcwrite", bus.PCWrite, 1'b0);
    step("lu_stall");
    check("lu_valid", bus.ID_EX_Valid, 1'b0);
    check("lu_stallcnt", bus.StallCount, 16'd1);
    step("lu_resume");
    check("lu_resume_rd", bus.ID_EX_RegisterRd, 5'd8);

    // No false stalls: lw x0, unused rs2 match, bubble in ID/EX.
    drive(instr(1, 2, 0, 1'b1, 1'b1, 32'h10c), 1'b1, 1'b1, 1'b0);
    step("lw_x0");
    drive(instr(0, 0, 9, 1'b0, 1'b1, 32'h110), 1'b1, 1'b1, 1'b0);
    step("x0_dep");
    drive(instr(1, 2, 5, 1'b1, 1'b1, 32'h114), 1'b1, 1'b1, 1'b0);
    step("lw2");
    drive(instr(1, 5, 9, 1'b0, 1'b1, 32'h118), 1'b1, 1'b0, 1'b0);
    step("nors2");
    drive(instr(1, 2, 5, 1'b1, 1'b1, 32'h11c), 1'b1, 1'b1, 1'b1);
    step("flush_lw");
    drive(instr(5, 5, 9, 1'b0, 1'b1, 32'h120), 1'b1, 1'b1, 1'b0);
    step("bubble_dep");

    // Flush beats load-use.
    drive(instr(1, 2, 5, 1'b1, 1'b1, 32'h124), 1'b1, 1'b1, 1'b0);
    step("lw3");
    drive(instr(5, 2, 9, 1'b0, 1'b1, 32'h128), 1'b1, 1'b1, 1'b1);
    step("flush_prio");
    check("flush_prio_stallcnt", bus.StallCount, 16'd1);
    check("flush_prio_flushcnt", bus.FlushCount, 16'd2);

    // Randomized traffic with dense register aliasing.
    for (int i = 0; i < 300; i++) begin
      drive(randIn(), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      step("rand");
    end

    // Async reset with a valid instruction and nonzero counters.
    drive(instr(1, 2, 3, 1'b0, 1'b1, 32'h200), 1'b0, 1'b0, 1'b0);
    step("pre_reset");
    #2 reset = 1'b1;
    modelReset();
    #1 checkOutputs("async_reset");
    reset = 1'b0;
    drive(instr(4, 5, 6, 1'b0, 1'b1, 32'h204), 1'b1, 1'b1, 1'b0);
    step("post_reset");
    check("post_reset_valid", bus.ID_EX_Valid, 1'b1);

    // Reset asserted during a stall discards it.
    drive(instr(1, 2, 5, 1'b1, 1'b1, 32'h208), 1'b1, 1'b1, 1'b0);
    step("lw4");
    drive(instr(5, 5, 10, 1'b0, 1'b1, 32'h20c), 1'b1, 1'b1, 1'b0);
    #1 check("midstall_pcwrite", bus.PCWrite, 1'b0);
    reset = 1'b1;
    modelReset();
    #1 check("midstall_reset_pcwrite", bus.PCWrite, 1'b1);
    reset = 1'b0;
    step("midstall_release");
    check("midstall_capture_pc", bus.ID_EX_PC, 32'h20c);

    // Stall counter saturation from a preloaded value.
    force bus.StallCount = 16'hFFFE;
    #1 release bus.StallCount;
    expStallCnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      drive(instr(1, 2, 5, 1'b1, 1'b1, 32'h300), 1'b1, 1'b1, 1'b0);
      step("sat_lw");
      drive(instr(5, 2, 11, 1'b0, 1'b1, 32'h304), 1'b1, 1'b1, 1'b0);
      step("sat_stall");
      check("sat_stallcnt", bus.StallCount, (i == 0) ? 16'hFFFF : 16'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
